// File: rtl/inst_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_stage_if
//
// Purpose: bundles the instruction-bus handshake and the decode-side
// handshake of the instruction fetch stage into one interface.
//
// Signals:
//   o_ibus_addr   fetch word address (bits[1:0] always 0)
//   o_ibus_req    read request, held with its address until i_ibus_ack
//   i_ibus_ack    read complete; i_ibus_rdata valid in this cycle
//   i_ibus_rdata  fetched instruction word
//   i_stall       decode cannot accept; presented outputs are held
//   i_redirect    one-cycle pulse: restart fetch at i_redirect_pc
//   i_redirect_pc redirect target
//   o_inst        instruction to decoder
//   o_pc          address of o_inst
//   o_valid       o_inst/o_pc valid
//   o_fault       misaligned fetch target; qualifies o_valid
//
// Modports:
//   master  the fetch stage itself
//   slave   the environment (instruction bus + decoder/redirect source)
// -----------------------------------------------------------------------------
interface inst_fetch_stage_if #(
  parameter int ADDR_WIDTH = 32
);
  // Instruction bus
  logic [ADDR_WIDTH-1:0] o_ibus_addr;
  logic                  o_ibus_req;
  logic                  i_ibus_ack;
  logic [31:0]           i_ibus_rdata;

  // Decode handshake and redirect
  logic                  i_stall;
  logic                  i_redirect;
  logic [ADDR_WIDTH-1:0] i_redirect_pc;
  logic [31:0]           o_inst;
  logic [ADDR_WIDTH-1:0] o_pc;
  logic                  o_valid;
  logic                  o_fault;

  modport master (
    output o_ibus_addr,
    output o_ibus_req,
    input  i_ibus_ack,
    input  i_ibus_rdata,
    input  i_stall,
    input  i_redirect,
    input  i_redirect_pc,
    output o_inst,
    output o_pc,
    output o_valid,
    output o_fault
  );

  modport slave (
    input  o_ibus_addr,
    input  o_ibus_req,
    output i_ibus_ack,
    output i_ibus_rdata,
    output i_stall,
    output i_redirect,
    output i_redirect_pc,
    input  o_inst,
    input  o_pc,
    input  o_valid,
    input  o_fault
  );
endinterface

// File: rtl/inst_fetch_stage.sv
// -----------------------------------------------------------------------------
// inst_fetch_stage
//
// Purpose: instruction fetch stage. Owns the fetch PC, issues single-word
// reads on the instruction bus (one outstanding at a time), buffers up to two
// fetched words (output register + one-entry skid) and presents inst/pc pairs
// to the decoder with a valid/stall handshake. Branch/jump/trap redirects
// restart fetch at a new PC; a misaligned target produces a held fault output.
//
// Ports:
//   i_clock   core clock, all state updates on the rising edge
//   i_reset   asynchronous, active-high reset
//   fetchIf   inst_fetch_stage_if.master (instruction bus + decode handshake)
//
// Parameters:
//   ADDR_WIDTH  PC and bus address width
//   RESET_PC    fetch address after reset (word aligned)
// -----------------------------------------------------------------------------
module inst_fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  inst_fetch_stage_if.master   fetchIf
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    FAULT   = 2'd3
  } fetchState_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fetchState_t           stateReg,        stateNext;

  logic [31:0]           outInstReg,      outInstNext;
  logic [ADDR_WIDTH-1:0] outPcReg,        outPcNext;
  logic                  outValidReg,     outValidNext;
  logic                  outFaultReg,     outFaultNext;

  logic [31:0]           skidInstReg,     skidInstNext;
  logic [ADDR_WIDTH-1:0] skidPcReg,       skidPcNext;
  logic                  skidValidReg,    skidValidNext;

  // fetchPcReg is the address of the next word to fetch, or the pending
  // restart target while the FSM is draining an abandoned request.
  logic [ADDR_WIDTH-1:0] fetchPcReg,      fetchPcNext;

  // Address of the abandoned request while in DISCARD: the bus must see the
  // old address until it acknowledges, even though fetchPcReg already holds
  // the new target.
  logic [ADDR_WIDTH-1:0] discardAddrReg,  discardAddrNext;

  // ---------------------------------------------------------------------------
  // Handshake helpers
  // ---------------------------------------------------------------------------
  logic                  reqActive;
  logic                  busAck;
  logic                  transfer;
  logic                  startNow;
  logic [ADDR_WIDTH-1:0] startPc;

  assign reqActive = (stateReg == FETCH) || (stateReg == DISCARD);
  // An ack is only meaningful while a request is outstanding.
  assign busAck    = reqActive && fetchIf.i_ibus_ack;
  assign transfer  = outValidReg && !fetchIf.i_stall;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext       = stateReg;
    outInstNext     = outInstReg;
    outPcNext       = outPcReg;
    outValidNext    = outValidReg;
    outFaultNext    = outFaultReg;
    skidInstNext    = skidInstReg;
    skidPcNext      = skidPcReg;
    skidValidNext   = skidValidReg;
    fetchPcNext     = fetchPcReg;
    discardAddrNext = discardAddrReg;
    startNow        = 1'b0;
    startPc         = fetchPcReg;

    if (fetchIf.i_redirect) begin
      // Redirect wins over stall, ack and transfer: flush everything buffered.
      outValidNext  = 1'b0;
      outFaultNext  = 1'b0;
      skidValidNext = 1'b0;
      fetchPcNext   = fetchIf.i_redirect_pc;

      unique case (stateReg)
        FETCH: begin
          if (busAck) begin
            // Word returning this cycle belongs to the old path: drop it.
            startNow = 1'b1;
            startPc  = fetchIf.i_redirect_pc;
          end else begin
            // Request cannot be withdrawn; drain it on the old address.
            stateNext       = DISCARD;
            discardAddrNext = fetchPcReg;
          end
        end
        DISCARD: begin
          // Only the target moves; the outstanding request stays put.
          if (busAck) begin
            startNow = 1'b1;
            startPc  = fetchIf.i_redirect_pc;
          end
        end
        default: begin
          // IDLE or FAULT: nothing outstanding, restart immediately.
          startNow = 1'b1;
          startPc  = fetchIf.i_redirect_pc;
        end
      endcase
    end else begin
      // Decode consumes the output; refill it from the skid if one is waiting.
      // The fault output is sticky and is only cleared by a redirect.
      if (transfer && (stateReg != FAULT)) begin
        outValidNext = 1'b0;
        if (skidValidReg) begin
          outInstNext   = skidInstReg;
          outPcNext     = skidPcReg;
          outValidNext  = 1'b1;
          skidValidNext = 1'b0;
        end
      end

      unique case (stateReg)
        IDLE: begin
          // Looking at the skid's next value lets fetch resume in the same
          // cycle the skid drains, so a released stall leaves no bubble.
          if (!skidValidNext) begin
            stateNext = FETCH;
          end
        end
        FETCH: begin
          if (busAck) begin
            if ((!outValidReg || transfer) && !skidValidReg) begin
              outInstNext  = fetchIf.i_ibus_rdata;
              outPcNext    = fetchPcReg;
              outValidNext = 1'b1;
            end else begin
              skidInstNext  = fetchIf.i_ibus_rdata;
              skidPcNext    = fetchPcReg;
              skidValidNext = 1'b1;
            end
            fetchPcNext = fetchPcReg + WORD_STEP;
            // Never issue a request without a free slot for its data.
            stateNext   = skidValidNext ? IDLE : FETCH;
          end
        end
        DISCARD: begin
          if (busAck) begin
            startNow = 1'b1;
            startPc  = fetchPcReg;
          end
        end
        default: begin
          // FAULT: hold until a redirect arrives.
        end
      endcase
    end

    // Common restart path: a misaligned target parks in FAULT with the fault
    // presented immediately; an aligned one resumes fetching.
    if (startNow) begin
      if (startPc[1:0] != 2'b00) begin
        stateNext    = FAULT;
        outValidNext = 1'b1;
        outFaultNext = 1'b1;
        outPcNext    = startPc;
        outInstNext  = NOP_INST;
      end else begin
        stateNext = FETCH;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      stateReg       <= IDLE;
      outInstReg     <= NOP_INST;
      outPcReg       <= RESET_PC;
      outValidReg    <= 1'b0;
      outFaultReg    <= 1'b0;
      skidInstReg    <= NOP_INST;
      skidPcReg      <= RESET_PC;
      skidValidReg   <= 1'b0;
      fetchPcReg     <= RESET_PC;
      discardAddrReg <= RESET_PC;
    end else begin
      stateReg       <= stateNext;
      outInstReg     <= outInstNext;
      outPcReg       <= outPcNext;
      outValidReg    <= outValidNext;
      outFaultReg    <= outFaultNext;
      skidInstReg    <= skidInstNext;
      skidPcReg      <= skidPcNext;
      skidValidReg   <= skidValidNext;
      fetchPcReg     <= fetchPcNext;
      discardAddrReg <= discardAddrNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered, so the bus sees stable req/addr all cycle)
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] busAddr;

  assign busAddr             = (stateReg == DISCARD) ? discardAddrReg : fetchPcReg;
  assign fetchIf.o_ibus_addr = {busAddr[ADDR_WIDTH-1:2], 2'b00};
  assign fetchIf.o_ibus_req  = reqActive;
  assign fetchIf.o_inst      = outInstReg;
  assign fetchIf.o_pc        = outPcReg;
  assign fetchIf.o_valid     = outValidReg;
  assign fetchIf.o_fault     = outFaultReg;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_stage
//
// Self-checking bench for inst_fetch_stage. Expected decode-side traffic is a
// simple stream model: after reset or a redirect to aligned T, decode must see
// T, T+4, T+8, ... with the memory word of each address; after a redirect to
// a misaligned T, decode must see a held fault entry for T. The driver pushes
// that stream into a queue; a monitor pops and compares on every transfer.
// A bus responder with random wait states checks request stability.
// -----------------------------------------------------------------------------
module tb_inst_fetch_stage;

  localparam int              AW       = 32;
  localparam logic [AW-1:0]   RESET_PC = 32'h0000_0000;
  localparam logic [31:0]     NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_stage_if #(.ADDR_WIDTH(AW)) busIf ();

  inst_fetch_stage #(
    .ADDR_WIDTH(AW),
    .RESET_PC  (RESET_PC)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .fetchIf(busIf)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Memory contents: any fixed function of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference stream model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t        expQ[$];
  bit          streamMode = 1'b0;
  logic [31:0] nextPushPc = 32'h0;

  function automatic void pushExp(input logic [31:0] pc, input logic [31:0] inst, input logic fault);
    exp_t e;
    e.pc = pc;
    e.inst = inst;
    e.fault = fault;
    expQ.push_back(e);
  endfunction

  function automatic void fillStream();
    while (streamMode && expQ.size() < 16) begin
      pushExp(nextPushPc, memWord(nextPushPc), 1'b0);
      nextPushPc = nextPushPc + 32'd4;
    end
  endfunction

  function automatic void startStream(input logic [31:0] target);
    expQ.delete();
    if (target[1:0] != 2'b00) begin
      streamMode = 1'b0;
      pushExp(target, NOP, 1'b1);
    end else begin
      streamMode = 1'b1;
      nextPushPc = target;
      fillStream();
    end
  endfunction

  always @(posedge clk) fillStream();

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  exp_t monE;
  int   idleCnt = 0;

  always @(negedge clk) begin
    if (rst || busIf.i_redirect) begin
      idleCnt = 0;
    end else begin
      if (busIf.o_valid && !busIf.i_stall) begin
        idleCnt = 0;
        $display("xfer pc=%h inst=%h fault=%0d", busIf.o_pc, busIf.o_inst, busIf.o_fault);
        if (expQ.size() == 0) begin
          check("sb_unexpected_xfer", busIf.o_pc, 32'hDEAD_BEEF);
        end else begin
          monE = expQ[0];
          if (!monE.fault) void'(expQ.pop_front());
          check("sb_pc", busIf.o_pc, monE.pc);
          check("sb_inst", busIf.o_inst, monE.inst);
          check("sb_fault", 32'(busIf.o_fault), 32'(monE.fault));
        end
      end else if (!busIf.o_valid) begin
        idleCnt++;
        if (idleCnt > 40) begin
          check("sb_output_timeout", 32'(busIf.o_valid), 32'd1);
          idleCnt = 0;
        end
      end
      if (busIf.o_fault) check("sb_req_in_fault", 32'(busIf.o_ibus_req), 32'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction bus responder
  // ---------------------------------------------------------------------------
  int          maxWait  = 0;
  logic [31:0] slowAddr = 32'hFFFF_FFFF;
  int          slowWait = 0;
  bit          inReq    = 1'b0;
  int          waitLeft = 0;
  logic [31:0] reqAddr  = 32'h0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      inReq = 1'b0;
      busIf.i_ibus_ack   = 1'b0;
      busIf.i_ibus_rdata = $urandom;
    end else if (busIf.o_ibus_req) begin
      if (!inReq) begin
        inReq   = 1'b1;
        reqAddr = busIf.o_ibus_addr;
        check("ibus_addr_align", 32'(busIf.o_ibus_addr[1:0]), 32'd0);
        if (busIf.o_ibus_addr == slowAddr) waitLeft = slowWait;
        else waitLeft = int'($urandom_range(maxWait, 0));
      end else begin
        check("ibus_addr_stable", busIf.o_ibus_addr, reqAddr);
      end
      if (waitLeft == 0) begin
        busIf.i_ibus_ack   = 1'b1;
        busIf.i_ibus_rdata = memWord(busIf.o_ibus_addr);
        inReq = 1'b0;
      end else begin
        busIf.i_ibus_ack   = 1'b0;
        busIf.i_ibus_rdata = $urandom;
        waitLeft--;
      end
    end else begin
      busIf.i_ibus_ack   = 1'b0;
      busIf.i_ibus_rdata = $urandom;
      if (inReq) check("ibus_req_held", 32'(busIf.o_ibus_req), 32'd1);
      inReq = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
    busIf.i_redirect = 1'b0;
  endtask

  task automatic doRedirect(input logic [31:0] target);
    busIf.i_redirect    = 1'b1;
    busIf.i_redirect_pc = target;
    startStream(target);
    $display("redirect to %h", target);
  endtask

  task automatic waitValid(input string name, input int limit);
    int n = 0;
    while (!busIf.o_valid && n < limit) begin
      tick();
      n++;
    end
    check(name, 32'(busIf.o_valid), 32'd1);
  endtask

  task automatic waitReq(input string name, input int limit);
    int n = 0;
    while (!busIf.o_ibus_req && n < limit) begin
      tick();
      n++;
    end
    check(name, 32'(busIf.o_ibus_req), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] t;
    int          n;
    int          sel;

    busIf.i_stall       = 1'b0;
    busIf.i_redirect    = 1'b0;
    busIf.i_redirect_pc = 32'h0;
    rst = 1'b1;
    startStream(RESET_PC);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(busIf.o_valid), 32'd0);
    check("rst_fault", 32'(busIf.o_fault), 32'd0);
    check("rst_req", 32'(busIf.o_ibus_req), 32'd0);
    check("rst_pc", busIf.o_pc, RESET_PC);
    check("rst_inst", busIf.o_inst, NOP);
    tick();
    rst = 1'b0;

    // Zero-wait streaming 0, 4, 8 then a 3-cycle stall on 8
    maxWait = 0;
    waitValid("zw_first_valid", 20);
    for (int i = 0; i < 3; i++) begin
      check("zw_valid", 32'(busIf.o_valid), 32'd1);
      check("zw_pc", busIf.o_pc, 32'(4 * i));
      if (i < 2) tick();
    end
    busIf.i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) busIf.i_stall = 1'b0;
      check("stall_valid", 32'(busIf.o_valid), 32'd1);
      check("stall_pc", busIf.o_pc, 32'd8);
      check("stall_inst", busIf.o_inst, memWord(32'd8));
      if (i < 2) check("stall_req_low", 32'(busIf.o_ibus_req), 32'd0);
    end
    tick();
    check("release_valid_12", 32'(busIf.o_valid), 32'd1);
    check("release_pc_12", busIf.o_pc, 32'd12);
    tick();
    check("release_valid_16", 32'(busIf.o_valid), 32'd1);
    check("release_pc_16", busIf.o_pc, 32'd16);

    // Reset mid-stream, then slow ack on address 4 with a redirect during it
    rst = 1'b1;
    startStream(RESET_PC);
    tick();
    check("rst2_valid", 32'(busIf.o_valid), 32'd0);
    check("rst2_req", 32'(busIf.o_ibus_req), 32'd0);
    slowAddr = 32'd4;
    slowWait = 3;
    tick();
    rst = 1'b0;
    n = 0;
    while (!(busIf.o_ibus_req && busIf.o_ibus_addr == 32'd4) && n < 20) begin
      tick();
      n++;
    end
    check("slow_req_seen", busIf.o_ibus_addr, 32'd4);
    doRedirect(32'h0000_0100);
    tick();
    n = 0;
    while (busIf.o_ibus_req && busIf.o_ibus_addr == 32'd4 && n < 10) begin
      tick();
      n++;
    end
    check("discard_next_req", 32'(busIf.o_ibus_req), 32'd1);
    check("discard_next_addr", busIf.o_ibus_addr, 32'h0000_0100);
    slowAddr = 32'hFFFF_FFFF;
    waitValid("discard_valid", 20);
    check("discard_pc", busIf.o_pc, 32'h0000_0100);

    // Redirect in the same cycle as a zero-wait ack
    waitReq("same_ack_req", 20);
    doRedirect(32'h0000_0300);
    tick();
    waitValid("same_ack_valid", 20);
    check("same_ack_pc", busIf.o_pc, 32'h0000_0300);

    // Misaligned target -> held fault, then resume
    doRedirect(32'h0000_0102);
    tick();
    n = 0;
    while (!busIf.o_fault && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      check("fault_valid", 32'(busIf.o_valid), 32'd1);
      check("fault_flag", 32'(busIf.o_fault), 32'd1);
      check("fault_pc", busIf.o_pc, 32'h0000_0102);
      check("fault_inst", busIf.o_inst, NOP);
      check("fault_req", 32'(busIf.o_ibus_req), 32'd0);
      tick();
    end
    doRedirect(32'h0000_0200);
    tick();
    waitValid("resume_valid", 20);
    check("resume_pc", busIf.o_pc, 32'h0000_0200);
    check("resume_fault", 32'(busIf.o_fault), 32'd0);

    // PC wrap at the top of the address space
    doRedirect(32'hFFFF_FFFC);
    tick();
    waitValid("wrap_valid", 20);
    check("wrap_pc_top", busIf.o_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_valid_next", 32'(busIf.o_valid), 32'd1);
    check("wrap_pc_zero", busIf.o_pc, 32'h0000_0000);

    // Randomized traffic: wait states, stalls, redirects (some misaligned)
    maxWait = 3;
    for (int c = 0; c < 1500; c++) begin
      tick();
      busIf.i_stall = (int'($urandom_range(99, 0)) < 25);
      if (int'($urandom_range(99, 0)) < 4) begin
        t   = {22'h0, 8'($urandom_range(255, 0)), 2'b00};
        sel = int'($urandom_range(9, 0));
        if (sel == 0) t[1:0] = 2'($urandom_range(3, 1));
        else if (sel == 1) t = 32'hFFFF_FFF0 | {28'h0, t[3:2], 2'b00};
        doRedirect(t);
      end
    end

    busIf.i_stall = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_stage.md
# inst_fetch_stage

Instruction fetch stage of the pipelined core. It owns the fetch PC, issues word reads on the instruction bus, and buffers up to two fetched words. It presents instruction/PC pairs to the instruction decoder with a valid/stall handshake, and restarts from a new PC on branch, jump or trap redirects.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset (word aligned)
- ADDR_WIDTH, 32, PC and bus address width
- i_clock  in  1  core clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- o_ibus_addr  out  ADDR_WIDTH  fetch word address (bits[1:0] always 0)
- o_ibus_req  out  1  read request
- i_ibus_ack  in  1  read complete; i_ibus_rdata valid this cycle
- i_ibus_rdata  in  32  fetched instruction word
- i_stall  in  1  decode cannot accept; o_inst/o_pc/o_valid/o_fault held
- i_redirect  in  1  one-cycle pulse: restart fetch at i_redirect_pc
- i_redirect_pc  in  ADDR_WIDTH  redirect target
- o_inst  out  32  instruction to decoder
- o_pc  out  ADDR_WIDTH  address of o_inst
- o_valid  out  1  o_inst/o_pc valid
- o_fault  out  1  misaligned fetch target; qualifies o_valid

## Operation
- Storage:
  - output register: inst, pc, valid, fault
  - one-entry skid register: inst, pc, valid
  - fetch_pc
  - FSM: IDLE, FETCH, DISCARD, FAULT
- A transfer to decode happens when o_valid && !i_stall.
- Bus rules:
  - o_ibus_req is high exactly in FETCH and DISCARD.
  - Once raised, o_ibus_req and o_ibus_addr are held stable until i_ibus_ack.
  - At most one request is outstanding.
  - Ack may arrive in the same cycle as req (zero-wait).
- IDLE: go to FETCH when the skid is empty.
- FETCH: o_ibus_addr = fetch_pc. On ack, the word goes to:
  - the output register, if it is empty or being transferred this cycle and the skid is empty;
  - otherwise, the skid.
- After an ack in FETCH:
  - fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH).
  - Stay in FETCH if the skid will be empty next cycle; otherwise go to IDLE.
- Requests are only issued with the skid empty, so an ack always has a destination.
- When the output is transferred and the skid is valid, the skid moves to the output and the skid clears.
- Redirect has priority over stall, ack and transfer:
  - Output valid, fault and skid valid clear next cycle.
  - fetch_pc <= i_redirect_pc.
- Redirect in FETCH with no ack that cycle → DISCARD.
- Redirect in FETCH with ack the same cycle → the word is dropped; go to FETCH at the new target.
- DISCARD:
  - The request stays on the old address.
  - On ack, the data is dropped and the FSM goes to FETCH (or FAULT) using the latest target.
  - A redirect in DISCARD only updates the target.
- Misaligned target (i_redirect_pc[1:0] != 0) → FAULT, after any DISCARD completes:
  - no requests;
  - o_valid = 1, o_fault = 1, o_pc = target, o_inst = 32'h0000_0013 (NOP);
  - held until the next redirect.
- o_inst drives the decoder instruction input directly; no decoding happens in this block.

## Timing
- During/after reset:
  - o_valid = 0, o_fault = 0, o_ibus_req = 0
  - o_pc = RESET_PC, o_inst = 32'h0000_0013
  - fetch_pc = RESET_PC, skid empty, FSM = IDLE
- First request in the cycle after reset deasserts (IDLE → FETCH at the first edge).
- Fetch latency: ack at edge N → o_valid at N+1. With a zero-wait bus, throughput is one instruction per cycle.
- Redirect latency:
  - Redirect sampled at edge N with no outstanding request → o_ibus_req at the new address from N+1.
  - With zero-wait, o_valid for the target at N+2.
- Redirect during an outstanding request adds the remaining wait of the old request.
- Stall with an outstanding request: the ack fills the skid, then the FSM goes to IDLE. Buffer capacity is 2 words.
- Reset mid-request: the request is abandoned immediately; the bus must tolerate an unacknowledged abort.

## Test plan
- Zero-wait bus, no stall, RESET_PC = 0 → o_pc sequence 0, 4, 8, 12 on consecutive cycles, each o_inst equal to the memory word.
- i_stall high 3 cycles while o_pc = 8 → o_pc/o_inst held at 8, skid holds 12, o_ibus_req low; after release, 12 and 16 follow with no gap and no duplicates.
- Ack delayed 3 cycles for address 4, redirect to 0x100 in wait cycle 1 → o_ibus_addr stays 4 until ack, word for 4 never reaches o_valid, next request is 0x100.
- Redirect and ack in the same cycle → acked word dropped; next o_valid carries o_pc = redirect target.
- Redirect to 0x102 → o_valid = 1, o_fault = 1, o_pc = 0x102, o_inst = 32'h13, no requests; redirect to 0x200 resumes normal fetch.
- fetch_pc = 32'hFFFF_FFFC, zero-wait → next fetch address 32'h0000_0000.
